// File: rtl/seg7_scan_driver.sv
// Five-digit multiplexed 7-segment driver: converts a 16-bit binary value to BCD
// with a sequential double-dabble and scans the digits with registered outputs.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100_000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] bin_inp,
    input  logic        bin_valid_i,
    output logic        bin_ready_o,
    output logic [7:0]  disp_an_o,
    output logic [7:0]  disp_seg_o
);

    typedef enum logic {ST_IDLE, ST_CONV} state_t;

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    state_t          state_q, state_d;
    logic [3:0]      iter_q, iter_d;
    logic [15:0]     shift_q, shift_d;
    logic [19:0]     bcd_q, bcd_d;
    logic [19:0]     disp_q, disp_d;
    logic            ready_q, ready_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      digit_q, digit_d;
    logic [7:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;

    logic [19:0]     adj;
    logic [19:0]     bcd_step;
    logic [3:0]      nibble;
    logic            blank;

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        disp_d   = disp_q;
        ready_d  = ready_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        an_d     = 8'hFF;
        seg_d    = 8'hFF;
        nibble   = 4'd0;
        blank    = 1'b0;

        // add-3 correction precedes the shift so every nibble stays a valid BCD digit
        adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        bcd_step = 20'({adj, shift_q[15]});

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bin_valid_i && ready_q) begin
                    shift_d = bin_inp;
                    bcd_d   = 20'd0;
                    iter_d  = 4'd0;
                    state_d = ST_CONV;
                    ready_d = 1'b0;
                end
            end
            ST_CONV: begin
                ready_d = 1'b0;
                bcd_d   = bcd_step;
                shift_d = {shift_q[14:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    disp_d  = bcd_step;
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            digit_d = (digit_q == 3'd4) ? 3'd0 : digit_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (digit_q)
            3'd1: begin nibble = disp_q[7:4];   blank = (disp_q[19:4]  == 16'd0); end
            3'd2: begin nibble = disp_q[11:8];  blank = (disp_q[19:8]  == 12'd0); end
            3'd3: begin nibble = disp_q[15:12]; blank = (disp_q[19:12] == 8'd0);  end
            3'd4: begin nibble = disp_q[19:16]; blank = (disp_q[19:16] == 4'd0);  end
            default: begin nibble = disp_q[3:0]; blank = 1'b0; end
        endcase
        blank = blank && BLANK_LZ;

        if (!blank) begin
            an_d[digit_q] = 1'b0;
            case (nibble)
                4'd0: seg_d = 8'hC0;
                4'd1: seg_d = 8'hF9;
                4'd2: seg_d = 8'hA4;
                4'd3: seg_d = 8'hB0;
                4'd4: seg_d = 8'h99;
                4'd5: seg_d = 8'h92;
                4'd6: seg_d = 8'h82;
                4'd7: seg_d = 8'hF8;
                4'd8: seg_d = 8'h80;
                4'd9: seg_d = 8'h90;
                default: seg_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            iter_q  <= 4'd0;
            shift_q <= 16'd0;
            bcd_q   <= 20'd0;
            disp_q  <= 20'd0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            digit_q <= 3'd0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bin_ready_o = ready_q;
    assign disp_an_o   = an_q;
    assign disp_seg_o  = seg_q;

endmodule
